imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate extender for the datapath decode stage. It accepts a narrow immediate with a per-word mode: sign-extend, zero-extend, sign-extend-and-shift for branch offsets, or upper-immediate placement. It drives the widened result through a valid/ready handshake. A 2-entry skid buffer keeps every output registered, including in_ready, so the block can sit between decode and execute without a combinational ready path.

---
 rtl/imm_pkg.sv | 23 ++
 rtl/imm_extend_core.sv | 59 +++++
 rtl/imm_extend_pipe.sv | 116 +++++++++++
 tb/tb_imm_extend_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg
// Shared definitions for the immediate-extension decode path:
//   - extension mode encodings carried alongside each immediate
//   - default immediate / datapath word widths
//   - state type for the registered skid-buffer handshake stage
package imm_pkg;

   localparam logic [1:0] MODE_SEXT     = 2'b00;  // sign-extend
   localparam logic [1:0] MODE_ZEXT     = 2'b01;  // zero-extend
   localparam logic [1:0] MODE_SEXT_SHL = 2'b10;  // sign-extend then shift (branch offset)
   localparam logic [1:0] MODE_UPPER    = 2'b11;  // place immediate in the top bits

   localparam int IMM_W  = 12;
   localparam int WORD_W = 32;

   // EMPTY: nothing held; ONE: output register valid; FULL: output + skid valid
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core
// Purely combinational immediate extender, reusable by any decode path.
// Ports:
//   data   [IN_W-1:0]   raw immediate
//   mode   [1:0]        extension mode (imm_pkg MODE_*)
//   result [OUT_W-1:0]  extended immediate
// Parameters: IN_W (immediate width), OUT_W (result width), SHIFT (left
// shift used by the sign-extend-and-shift mode).
module imm_extend_core
   import imm_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W,
   parameter int SHIFT = 1
) (
   input  logic [IN_W-1:0]  data,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] result
);

   // The shifted mode must never drop bits, so the result must be wide
   // enough for the immediate plus the shift.
   if ((OUT_W < IN_W + SHIFT) || (OUT_W < IN_W) || (SHIFT < 0)) begin : g_bad_params
      $error("imm_extend_core: OUT_W must be >= IN_W + SHIFT and >= IN_W");
   end

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] upper;

   // Built bit by bit so that OUT_W == IN_W needs no zero-width replication.
   for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
      if (gi < IN_W) begin : g_low
         assign sext[gi] = data[gi];
         assign zext[gi] = data[gi];
      end else begin : g_high
         assign sext[gi] = data[IN_W-1];
         assign zext[gi] = 1'b0;
      end

      if (gi >= OUT_W - IN_W) begin : g_up
         assign upper[gi] = data[gi-(OUT_W-IN_W)];
      end else begin : g_up_zero
         assign upper[gi] = 1'b0;
      end
   end

   always_comb begin
      result = sext;
      case (mode)
         MODE_SEXT:     result = sext;
         MODE_ZEXT:     result = zext;
         MODE_SEXT_SHL: result = sext << SHIFT;
         MODE_UPPER:    result = upper;
         default:       result = sext;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Registered immediate extender with a valid/ready handshake on both sides.
// An output register plus one skid register keep every output (including
// in_ready) driven from flops, so no combinational ready path crosses it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready registered)
//   in_data [IN_W-1:0]       raw immediate
//   in_mode [1:0]            extension mode for this word
//   out_valid/out_ready      downstream handshake
//   out_data [OUT_W-1:0]     extended result
//   out_mode [1:0]           mode the result was produced with
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W,
   parameter int SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [1:0]       out_mode
);

   logic [OUT_W-1:0] ext_data;

   imm_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_core (
      .data   (in_data),
      .mode   (in_mode),
      .result (ext_data)
   );

   state_t           state_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;
   logic [OUT_W-1:0] o_data_reg;
   logic [1:0]       o_mode_reg;
   logic [OUT_W-1:0] s_data_reg;
   logic [1:0]       s_mode_reg;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid && in_ready_reg;
   assign out_fire = out_valid_reg && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= EMPTY;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         o_data_reg    <= '0;
         o_mode_reg    <= '0;
         s_data_reg    <= '0;
         s_mode_reg    <= '0;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_fire) begin
                  o_data_reg    <= ext_data;
                  o_mode_reg    <= in_mode;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  o_data_reg <= ext_data;
                  o_mode_reg <= in_mode;
               end else if (in_fire) begin
                  // Output is stalled: park the word and close the input
                  // from the next cycle on.
                  s_data_reg   <= ext_data;
                  s_mode_reg   <= in_mode;
                  in_ready_reg <= 1'b0;
                  state_reg    <= FULL;
               end else if (out_fire) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the output side can move.
               if (out_fire) begin
                  o_data_reg   <= s_data_reg;
                  o_mode_reg   <= s_mode_reg;
                  in_ready_reg <= 1'b1;
                  state_reg    <= ONE;
               end
            end
            default: begin
               state_reg     <= EMPTY;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = o_data_reg;
   assign out_mode  = o_mode_reg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
// Self-checking bench for imm_extend_pipe with default parameters.
// A queue of expected {mode, data} words is the reference: an accepted word
// is pushed with its arithmetically computed extension, and the head of the
// queue must be on the output whenever out_valid is high. Occupancy of the
// queue gives the expected out_valid and in_ready.
module tb_imm_extend_pipe;

   localparam int IN_W  = 12;
   localparam int OUT_W = 32;
   localparam int SHIFT = 1;

   typedef struct packed {
      logic [1:0]       mode;
      logic [OUT_W-1:0] data;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [1:0]       out_mode;

   int checks   = 0;
   int failures = 0;

   exp_t             q[$];
   logic             stalled = 1'b0;
   logic [OUT_W-1:0] held_data;
   logic [1:0]       held_mode;

   imm_extend_pipe #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mode  (out_mode)
   );

   always #5 clk = ~clk;

   // Reference extension: interpret the immediate as a number and scale it.
   function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] d, input logic [1:0] m);
      longint u;
      longint s;
      longint v;
      u = longint'(d);
      s = (u >= (64'sd1 << (IN_W-1))) ? u - (64'sd1 << IN_W) : u;
      case (m)
         2'd0:    v = s;
         2'd1:    v = u;
         2'd2:    v = s * (64'sd1 << SHIFT);
         default: v = u * (64'sd1 << (OUT_W-IN_W));
      endcase
      return v[OUT_W-1:0];
   endfunction

   task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      checks++;
      failures++;
      $error("FAIL %s: observed=timeout expected=completion", tag);
   endtask

   // One clock cycle: drive inputs at the falling edge, check the registered
   // outputs against the model, then advance the model by the handshakes.
   task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic [1:0] m,
                        input logic ordy, output logic acc);
      logic in_fire;
      logic out_fire;
      in_valid  = v;
      in_data   = d;
      in_mode   = m;
      out_ready = ordy;
      check("out_valid", OUT_W'(out_valid), OUT_W'(q.size() > 0));
      check("in_ready", OUT_W'(in_ready), OUT_W'(q.size() < 2));
      if (out_valid && q.size() > 0) begin
         check("out_data", out_data, q[0].data);
         check("out_mode", OUT_W'(out_mode), OUT_W'(q[0].mode));
      end
      if (stalled) begin
         check("stall_data", out_data, held_data);
         check("stall_mode", OUT_W'(out_mode), OUT_W'(held_mode));
      end
      in_fire  = v && in_ready;
      out_fire = out_valid && ordy;
      stalled   = out_valid && !ordy;
      held_data = out_data;
      held_mode = out_mode;
      if (out_fire && q.size() > 0) void'(q.pop_front());
      if (in_fire) q.push_back('{mode: m, data: ref_ext(d, m)});
      acc = in_fire;
      @(negedge clk);
   endtask

   task automatic send(input logic [IN_W-1:0] d, input logic [1:0] m, input logic ordy);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         cycle(1'b1, d, m, ordy, acc);
         n++;
      end
      if (!acc) fail_now("send");
   endtask

   task automatic drain();
      logic acc;
      int   n;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         cycle(1'b0, '0, 2'd0, 1'b1, acc);
         n++;
      end
      if (q.size() > 0) fail_now("drain");
      cycle(1'b0, '0, 2'd0, 1'b1, acc);
   endtask

   // Reset with a word offered in the same cycle: the word must be dropped.
   task automatic do_reset();
      in_valid  = 1'b1;
      in_data   = 12'h5A5;
      in_mode   = 2'd1;
      out_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      q.delete();
      stalled = 1'b0;
      check("rst_out_valid", OUT_W'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_out_mode", OUT_W'(out_mode), '0);
      check("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
   endtask

   initial begin
      logic             acc;
      logic             v;
      logic [IN_W-1:0]  d;
      logic [1:0]       m;
      int               sent;
      int               n;

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_mode = '0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      do_reset();

      // Every mode on 0x800, output always ready.
      for (int i = 0; i < 4; i++) send(12'h800, 2'(i), 1'b1);
      drain();

      // Shifted-mode edge values and upper placement.
      send(12'h7FF, 2'd2, 1'b1);
      send(12'hFFF, 2'd2, 1'b1);
      send(12'hABC, 2'd3, 1'b1);
      drain();

      // Back-pressure: two words fill the buffer, the third waits.
      cycle(1'b1, 12'h001, 2'd0, 1'b0, acc);
      cycle(1'b1, 12'h002, 2'd1, 1'b0, acc);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 12'h003, 2'd0, 1'b0, acc);
         if (acc) fail_now("held_word_accepted");
      end
      send(12'h003, 2'd0, 1'b1);
      drain();

      // Streaming: one word per cycle, in_ready never drops.
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 12'(i * 257), 2'(i), 1'b1, acc);
         if (!acc) fail_now("stream_accept");
      end
      drain();

      // Reset from FULL, then a single word emerges alone.
      cycle(1'b1, 12'h111, 2'd0, 1'b0, acc);
      cycle(1'b1, 12'h222, 2'd3, 1'b0, acc);
      cycle(1'b0, '0, 2'd0, 1'b0, acc);
      do_reset();
      send(12'h9A1, 2'd2, 1'b1);
      drain();

      // Random traffic and back-pressure.
      sent = 0;
      n = 0;
      v = 1'b0;
      d = 12'($urandom);
      m = 2'($urandom);
      while (sent < 200 && n < 5000) begin
         if (!v) v = ($urandom_range(0, 3) != 0);
         cycle(v, d, m, 1'($urandom_range(0, 1)), acc);
         if (acc) begin
            sent++;
            v = 1'b0;
            d = 12'($urandom);
            m = 2'($urandom);
         end
         n++;
      end
      if (sent < 200) fail_now("random_send");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
